// File: rtl/flash_addr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : flash_addr_sequencer
//  Brief    : Row-address sequencer for record/play passes over a flash array.
//             Advances one row per packet (or on a forced prepacket), with
//             one-shot or looping behaviour at LAST_ROW.
//             Optional macro SEGMENT_START_EN adds a start_row input that sets
//             both the starting row and the loop-wrap row of a pass.
//  Revision : 1.0 - initial release
// ============================================================================
module flash_addr_sequencer #(
    parameter int ROW_W    = 10,
    parameter int COL_W    = 5,
    parameter int LAST_ROW = 936,
    parameter int PKT_LEN  = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             rec_start,
    input  logic                             play_start,
    input  logic                             stop,
    input  logic                             loop_mode,
    input  logic                             prepacket,
    input  logic [$clog2(PKT_LEN)-1:0]       bit_cnt,
`ifdef SEGMENT_START_EN
    input  logic [ROW_W-1:0]                 start_row,
`endif
    output logic [ROW_W+COL_W:0]             address,
    output logic                             busy,
    output logic                             is_rec,
    output logic                             wrap,
    output logic                             done
);

    localparam int               CNT_W      = $clog2(PKT_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(PKT_LEN - 1);
    localparam logic [ROW_W-1:0] LAST_ROW_V = ROW_W'(LAST_ROW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic             is_rec_nxt, wrap_nxt, done_nxt, busy_nxt;
    logic [ROW_W-1:0] start_val;   // row a new pass begins at
    logic [ROW_W-1:0] wrap_row;    // row a looping pass returns to
    logic             start_any;
    logic             advance;

`ifdef SEGMENT_START_EN
    logic [ROW_W-1:0] seg_row, seg_row_nxt;

    // Clamp the requested segment start so no row beyond LAST_ROW is ever used
    always_comb begin
        start_val = (start_row > LAST_ROW_V) ? LAST_ROW_V : start_row;
        wrap_row  = seg_row;
    end
`else
    // Passes always begin and wrap at row 0
    always_comb begin
        start_val = '0;
        wrap_row  = '0;
    end
`endif

    assign start_any = rec_start | play_start;
    // A packet boundary and a prepacket in the same cycle count as one advance
    assign advance   = (state == RUN) & (prepacket | (bit_cnt == LAST_BIT));

    // Address layout: fixed high bit, row field, column field held at zero
    assign address   = {1'b1, row, {COL_W{1'b0}}};

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            row    <= '0;
            busy   <= 1'b0;
            is_rec <= 1'b0;
            wrap   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            row    <= row_nxt;
            busy   <= busy_nxt;
            is_rec <= is_rec_nxt;
            wrap   <= wrap_nxt;
            done   <= done_nxt;
        end
    end

`ifdef SEGMENT_START_EN
    // Segment start row captured on every start, reused on each loop wrap
    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_row <= '0;
        end else begin
            seg_row <= seg_row_nxt;
        end
    end
`endif

    // Next-state logic; priority start > stop > advance
    always_comb begin
        state_nxt  = state;
        row_nxt    = row;
        is_rec_nxt = is_rec;
        wrap_nxt   = 1'b0;
        done_nxt   = 1'b0;
`ifdef SEGMENT_START_EN
        seg_row_nxt = seg_row;
`endif
        if (start_any) begin
            state_nxt  = RUN;
            row_nxt    = start_val;
            is_rec_nxt = rec_start;
`ifdef SEGMENT_START_EN
            seg_row_nxt = start_val;
`endif
        end else if (stop && (state == RUN)) begin
            state_nxt = IDLE;
        end else if (advance) begin
            if (row < LAST_ROW_V) begin
                row_nxt = row + ROW_W'(1);
            end else if (loop_mode) begin
                row_nxt  = wrap_row;
                wrap_nxt = 1'b1;
            end else begin
                done_nxt  = 1'b1;
                state_nxt = DONE;
            end
        end
        busy_nxt = (state_nxt == RUN);
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_addr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flash_addr_sequencer
//  Brief    : Self-checking bench for flash_addr_sequencer: directed boundary
//             passes followed by randomized control traffic, compared every
//             cycle against a behavioural model. Honors SEGMENT_START_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flash_addr_sequencer;

    localparam int ROW_W    = 10;
    localparam int COL_W    = 5;
    localparam int LAST_ROW = 936;
    localparam int PKT_LEN  = 32;
    localparam int CNT_W    = $clog2(PKT_LEN);

    logic                   clk;
    logic                   reset;
    logic                   rec_start;
    logic                   play_start;
    logic                   stop;
    logic                   loop_mode;
    logic                   prepacket;
    logic [CNT_W-1:0]       bit_cnt;
`ifdef SEGMENT_START_EN
    logic [ROW_W-1:0]       start_row;
`endif
    logic [ROW_W+COL_W:0]   address;
    logic                   busy;
    logic                   is_rec;
    logic                   wrap;
    logic                   done;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wrap  = 0;
    int n_done  = 0;

    // Behavioural model: 0 = idle, 1 = running, 2 = finished
    int m_mode  = 0;
    int m_row   = 0;
    int m_seg   = 0;
    int m_isrec = 0;
    int m_wrap  = 0;
    int m_done  = 0;

    flash_addr_sequencer #(
        .ROW_W    (ROW_W),
        .COL_W    (COL_W),
        .LAST_ROW (LAST_ROW),
        .PKT_LEN  (PKT_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rec_start  (rec_start),
        .play_start (play_start),
        .stop       (stop),
        .loop_mode  (loop_mode),
        .prepacket  (prepacket),
        .bit_cnt    (bit_cnt),
`ifdef SEGMENT_START_EN
        .start_row  (start_row),
`endif
        .address    (address),
        .busy       (busy),
        .is_rec     (is_rec),
        .wrap       (wrap),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply the pass rules to the model for the upcoming clock edge
    task automatic model_step();
        int start_eff;
        start_eff = 0;
`ifdef SEGMENT_START_EN
        start_eff = (int'(start_row) > LAST_ROW) ? LAST_ROW : int'(start_row);
`endif
        m_wrap = 0;
        m_done = 0;
        if (!reset) begin
            m_mode = 0; m_row = 0; m_isrec = 0; m_seg = 0;
        end else if (rec_start || play_start) begin
            m_mode = 1; m_row = start_eff; m_seg = start_eff;
            m_isrec = rec_start ? 1 : 0;
        end else if (stop && m_mode == 1) begin
            m_mode = 0;
        end else if (m_mode == 1 && (prepacket || int'(bit_cnt) == PKT_LEN - 1)) begin
            if (m_row < LAST_ROW) begin
                m_row = m_row + 1;
            end else if (loop_mode) begin
                m_row = m_seg; m_wrap = 1;
            end else begin
                m_done = 1; m_mode = 2;
            end
        end
    endtask

    function automatic logic [31:0] exp_addr();
        return 32'((1 << (ROW_W + COL_W)) + (m_row << COL_W));
    endfunction

    // One clock: advance the model, let the DUT clock, compare all outputs
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (wrap) n_wrap++;
        if (done) n_done++;
        check("address", 32'(address), exp_addr());
        check("busy",    32'(busy),    32'(m_mode == 1));
        check("is_rec",  32'(is_rec),  32'(m_isrec));
        check("wrap",    32'(wrap),    32'(m_wrap));
        check("done",    32'(done),    32'(m_done));
    endtask

    initial begin
        reset = 1'b0; rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
        loop_mode = 1'b0; prepacket = 1'b0; bit_cnt = '0;
`ifdef SEGMENT_START_EN
        start_row = '0;
`endif
        // Reset held for two cycles
        repeat (2) tick();
        check("rst_addr", 32'(address), 32'h8000);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;

        // Play pass, three full packets
        play_start = 1'b1; tick(); play_start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < PKT_LEN; b++) begin
                bit_cnt = CNT_W'(b);
                tick();
            end
        end
        bit_cnt = '0;
        check("play_addr", 32'(address), 32'h8060);
        check("play_is_rec", 32'(is_rec), 32'h0);

        // One-shot record pass to the last row
        loop_mode = 1'b0;
        rec_start = 1'b1; tick(); rec_start = 1'b0;
        n_wrap = 0; n_done = 0;
        prepacket = 1'b1; repeat (937) tick(); prepacket = 1'b0;
        check("oneshot_addr", 32'(address), 32'hF500);
        check("oneshot_done_cnt", 32'(n_done), 32'd1);
        check("oneshot_busy", 32'(busy), 32'h0);
        check("oneshot_is_rec", 32'(is_rec), 32'h1);
        prepacket = 1'b1; repeat (3) tick(); prepacket = 1'b0;
        check("done_hold_addr", 32'(address), 32'hF500);
        check("done_hold_cnt", 32'(n_done), 32'd1);

        // Looping record pass across the end
        loop_mode = 1'b1;
        rec_start = 1'b1; tick(); rec_start = 1'b0;
        n_wrap = 0; n_done = 0;
        prepacket = 1'b1; repeat (937) tick(); prepacket = 1'b0;
        check("loop_addr", 32'(address), 32'h8000);
        check("loop_wrap_cnt", 32'(n_wrap), 32'd1);
        check("loop_done_cnt", 32'(n_done), 32'd0);
        check("loop_busy", 32'(busy), 32'h1);

        // Coincident prepacket and packet end advance once
        play_start = 1'b1; tick(); play_start = 1'b0;
        prepacket = 1'b1; repeat (5) tick();
        check("row5_addr", 32'(address), 32'h80A0);
        bit_cnt = CNT_W'(PKT_LEN - 1); tick();
        prepacket = 1'b0; bit_cnt = '0;
        check("both_adv_addr", 32'(address), 32'h80C0);

        // Start beats stop
        stop = 1'b1; rec_start = 1'b1; tick(); stop = 1'b0; rec_start = 1'b0;
        check("start_stop_addr", 32'(address), 32'h8000);
        check("start_stop_busy", 32'(busy), 32'h1);
        check("start_stop_rec", 32'(is_rec), 32'h1);

        // Stop holds row; advances ignored in idle
        prepacket = 1'b1; repeat (4) tick(); prepacket = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_busy", 32'(busy), 32'h0);
        check("stop_addr", 32'(address), 32'h8080);
        prepacket = 1'b1; bit_cnt = CNT_W'(PKT_LEN - 1); repeat (3) tick();
        prepacket = 1'b0; bit_cnt = '0;
        check("idle_hold_addr", 32'(address), 32'h8080);

        // Reset at the last row aborts silently
        loop_mode = 1'b1;
        play_start = 1'b1; tick(); play_start = 1'b0;
        prepacket = 1'b1; repeat (936) tick();
        check("at_last_addr", 32'(address), 32'hF500);
        n_wrap = 0; n_done = 0;
        reset = 1'b0; tick(); reset = 1'b1; prepacket = 1'b0;
        check("rst_mid_addr", 32'(address), 32'h8000);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_pulses", 32'(n_wrap + n_done), 32'd0);

`ifdef SEGMENT_START_EN
        // Segment start and wrap back to it
        start_row = ROW_W'(100); loop_mode = 1'b1;
        rec_start = 1'b1; tick(); rec_start = 1'b0;
        check("seg_start_addr", 32'(address), 32'h8C80);
        n_wrap = 0;
        prepacket = 1'b1; repeat (837) tick(); prepacket = 1'b0;
        check("seg_wrap_addr", 32'(address), 32'h8C80);
        check("seg_wrap_cnt", 32'(n_wrap), 32'd1);
        // Out-of-range start clamps to the last row
        start_row = ROW_W'(1000);
        play_start = 1'b1; tick(); play_start = 1'b0;
        check("seg_clamp_addr", 32'(address), 32'hF500);
        start_row = '0;
`endif

        // Random phase A: busy control traffic
        for (int i = 0; i < 2500; i++) begin
            reset      = ($urandom_range(0, 299) != 0);
            rec_start  = ($urandom_range(0, 59) == 0);
            play_start = ($urandom_range(0, 59) == 0);
            stop       = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 49) == 0) loop_mode = ~loop_mode;
            prepacket  = ($urandom_range(0, 1) == 0);
            bit_cnt    = CNT_W'($urandom_range(0, PKT_LEN - 1));
`ifdef SEGMENT_START_EN
            start_row  = ROW_W'($urandom_range(0, (1 << ROW_W) - 1));
`endif
            tick();
        end

        // Random phase B: long passes that reach the end of the array
        reset = 1'b1; stop = 1'b0; rec_start = 1'b0;
        play_start = 1'b1; tick(); play_start = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            reset      = ($urandom_range(0, 4999) != 0);
            rec_start  = ($urandom_range(0, 1499) == 0);
            play_start = ($urandom_range(0, 1499) == 0);
            stop       = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 299) == 0) loop_mode = ~loop_mode;
            prepacket  = ($urandom_range(0, 3) != 0);
            bit_cnt    = CNT_W'($urandom_range(0, PKT_LEN - 1));
`ifdef SEGMENT_START_EN
            start_row  = ROW_W'($urandom_range(700, (1 << ROW_W) - 1));
`endif
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
